// File: rtl/hack_trace_buffer_pkg.sv
// Shared definitions for the Hack execution-trace capture block: FSM state
// encodings, trigger mode encodings and record field layout helpers.
package hack_trace_defs;

  // Capture FSM states; values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_e;

  // Trigger source selection.
  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_PC    = 2'd1,
    TRIG_WRITE = 2'd2,
    TRIG_EXT   = 2'd3
  } trig_mode_e;

  // Default tap widths of the Hack CPU.
  localparam int unsigned HACK_DATA_W = 16;
  localparam int unsigned HACK_ADDR_W = 15;

  // Record layout, MSB first: {pc, inst, addressM, dReg, outM, writeM}.
  function automatic int unsigned rec_width(int unsigned aw, int unsigned dw);
    return 2 * aw + 3 * dw + 1;
  endfunction

  function automatic int unsigned rec_off_writem();
    return 0;
  endfunction

  function automatic int unsigned rec_off_outm();
    return 1;
  endfunction

  function automatic int unsigned rec_off_dreg(int unsigned dw);
    return 1 + dw;
  endfunction

  function automatic int unsigned rec_off_addr(int unsigned dw);
    return 1 + 2 * dw;
  endfunction

  function automatic int unsigned rec_off_inst(int unsigned aw, int unsigned dw);
    return 1 + 2 * dw + aw;
  endfunction

  function automatic int unsigned rec_off_pc(int unsigned aw, int unsigned dw);
    return 1 + 3 * dw + aw;
  endfunction

endpackage

// File: rtl/hack_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x REC_W array with one write port and one
// synchronous, enable-gated read port. The array itself is not reset.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned REC_W = 79,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [REC_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [REC_W-1:0] rdata_o
);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: output only changes on an accepted read, so it holds between reads.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hack_trace_buffer.sv
// Execution-trace capture for the Hack computer: records one tap sample per
// valid CPU cycle into a circular buffer, stops a programmable number of
// samples after a trigger, and offers indexed readout (0 = oldest sample).
module hack_trace_buffer
  import hack_trace_defs::*;
#(
  parameter int unsigned DATA_W    = HACK_DATA_W,
  parameter int unsigned ADDR_W    = HACK_ADDR_W,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 16,
  localparam int unsigned REC_W    = rec_width(ADDR_W, DATA_W),
  localparam int unsigned IW       = $clog2(DEPTH),
  localparam int unsigned CW       = IW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_valid,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] addressM,
  input  logic [DATA_W-1:0] dReg,
  input  logic [DATA_W-1:0] outM,
  input  logic              writeM,
  input  logic              arm,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] trig_value,
  input  logic              trig_in,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_index,
  output logic [REC_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [1:0]        state,
  output logic [CW-1:0]     count,
  output logic [IW-1:0]     trig_pos
);

  localparam int unsigned OFF_PC   = rec_off_pc(ADDR_W, DATA_W);
  localparam int unsigned OFF_INST = rec_off_inst(ADDR_W, DATA_W);
  localparam int unsigned OFF_ADDR = rec_off_addr(DATA_W);
  localparam int unsigned OFF_DREG = rec_off_dreg(DATA_W);
  localparam int unsigned OFF_OUTM = rec_off_outm();
  localparam int unsigned OFF_WRM  = rec_off_writem();
  localparam bit          NO_POST  = (POST_TRIG == 0);

  trace_state_e     state_q;
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    wr_ptr_q;
  logic [IW-1:0]    post_q;
  logic [IW-1:0]    trig_pos_q;
  logic             rd_valid_q;
  logic             rd_err_q;
  logic             rd_ok_q;

  logic [CW-1:0]    count_d;
  logic [IW-1:0]    trig_pos_d;
  logic [IW-1:0]    rd_addr_d;
  logic [REC_W-1:0] wr_rec_d;
  logic [REC_W-1:0] ram_rdata;
  logic             capture_d;
  logic             trig_hit_d;
  logic             rd_accept_d;

  // Assemble the tap record in its readout layout.
  always_comb begin
    wr_rec_d                        = '0;
    wr_rec_d[OFF_PC   +: ADDR_W]    = pc;
    wr_rec_d[OFF_INST +: DATA_W]    = inst;
    wr_rec_d[OFF_ADDR +: ADDR_W]    = addressM;
    wr_rec_d[OFF_DREG +: DATA_W]    = dReg;
    wr_rec_d[OFF_OUTM +: DATA_W]    = outM;
    wr_rec_d[OFF_WRM]               = writeM;
  end

  // Trigger compare on the current sample.
  always_comb begin
    trig_hit_d = 1'b0;
    case (trig_mode_e'(trig_mode))
      TRIG_IMM:   trig_hit_d = 1'b1;
      TRIG_PC:    trig_hit_d = (pc == trig_value);
      TRIG_WRITE: trig_hit_d = writeM && (addressM == trig_value);
      TRIG_EXT:   trig_hit_d = trig_in;
      default:    trig_hit_d = 1'b0;
    endcase
  end

  // Capture qualification, saturating count, trigger position and read address.
  always_comb begin
    capture_d   = cap_valid && !arm && ((state_q == ST_PRE) || (state_q == ST_POST));
    count_d     = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
    trig_pos_d  = IW'(count_d - CW'(1) - CW'(POST_TRIG));
    rd_accept_d = rd_en && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                  ({1'b0, rd_index} < count_q);
    // With count == DEPTH the truncated count is 0, so the oldest entry is wr_ptr itself.
    rd_addr_d   = wr_ptr_q - count_q[IW-1:0] + rd_index;
  end

  // Capture FSM with pointers, post-trigger counter and trigger position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      post_q     <= '0;
      trig_pos_q <= '0;
    end else if (arm) begin
      state_q    <= ST_PRE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      post_q     <= '0;
      trig_pos_q <= '0;
    end else if (capture_d) begin
      wr_ptr_q <= wr_ptr_q + IW'(1);
      count_q  <= count_d;
      case (state_q)
        ST_PRE: begin
          if (trig_hit_d) begin
            if (NO_POST) begin
              state_q    <= ST_DONE;
              trig_pos_q <= trig_pos_d;
            end else begin
              state_q <= ST_POST;
              post_q  <= IW'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          post_q <= post_q - IW'(1);
          if (post_q == IW'(1)) begin
            state_q    <= ST_DONE;
            trig_pos_q <= trig_pos_d;
          end
        end
        default: ;
      endcase
    end
  end

  // Read response flags: one valid pulse per request, error/ok held until the next request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_err_q <= !rd_accept_d;
        rd_ok_q  <= rd_accept_d;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (capture_d),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec_d),
    .re_i    (rd_accept_d),
    .raddr_i (rd_addr_d),
    .rdata_o (ram_rdata)
  );

  // Rejected reads and the post-reset state present zero data.
  assign rd_data  = rd_ok_q ? ram_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign state    = state_q;
  assign count    = count_q;
  assign trig_pos = trig_pos_q;

endmodule

// File: doc/hack_trace_buffer.md
# hack_trace_buffer

Parametrised, synthesizable execution-trace capture block for the Hack computer. It records one record per retired CPU cycle (pc, instruction, addressM, D, outM, writeM) into a circular buffer with a configurable trigger and post-trigger depth. Captured samples are read back through an indexed port. It sits beside `Computer`, tapping the same signals the bench monitor prints, so long runs can be inspected in hardware or simulation without `$monitor` floods.

## Interface
- `DATA_W`, 16: data/instruction width.
- `ADDR_W`, 15: pc and addressM width.
- `DEPTH`, 64: buffer entries; power of two, ≥4.
- `POST_TRIG`, 16: samples stored after the trigger sample; must satisfy 0 ≤ POST_TRIG ≤ DEPTH-1.
- `REC_W`, derived: 2·ADDR_W + 3·DATA_W + 1 (79 at defaults).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cap_valid` in 1: the tap inputs hold a valid CPU cycle this clock.
- `pc`, `addressM` in ADDR_W: CPU taps.
- `inst`, `dReg`, `outM` in DATA_W: CPU taps.
- `writeM` in 1: CPU tap.
- `arm` in 1: one-cycle pulse; starts or restarts capture.
- `trig_mode` in 2: 0 immediate, 1 pc match, 2 write to address, 3 external.
- `trig_value` in ADDR_W: compare value for modes 1 and 2.
- `trig_in` in 1: external trigger for mode 3.
- `rd_en` in 1: read request.
- `rd_index` in log2(DEPTH): 0 = oldest stored sample.
- `rd_data` out REC_W: record {pc, inst, addressM, dReg, outM, writeM}, MSB first.
- `rd_valid` out 1: rd_data valid.
- `rd_err` out 1: the last read was rejected.
- `state` out 2: 0 IDLE, 1 PRE, 2 POST, 3 DONE.
- `count` out log2(DEPTH)+1: stored samples, saturates at DEPTH.
- `trig_pos` out log2(DEPTH): readout index of the trigger sample; valid in DONE.

## Operation
- **IDLE**: nothing captured. `arm` moves to PRE, clears count and write pointer.
- **PRE**: every `cap_valid` sample is written at wr_ptr; wr_ptr wraps modulo DEPTH; count saturates at DEPTH, overwriting the oldest sample.
  - Trigger condition, evaluated on the same sample: mode 0 always; mode 1 `pc==trig_value`; mode 2 `writeM && addressM==trig_value`; mode 3 `trig_in`.
  - On a trigger, the trigger sample is stored, post counter = POST_TRIG, and the block goes to POST, or directly to DONE if POST_TRIG=0.
- **POST**: stores `cap_valid` samples and decrements the post counter; on the sample that makes it 0, goes to DONE.
- **DONE**: capture frozen. trig_pos = count-1-POST_TRIG.
- Readout: physical address = (wr_ptr - count + rd_index) mod DEPTH.
  - Honoured only in IDLE or DONE with rd_index < count.
  - Any other read sets rd_err=1 and rd_data=0 with rd_valid=1.
- `arm` in any state restarts: count, pointers and post counter are cleared, and the block enters PRE.
- Same-cycle `arm` + `cap_valid`: the arm wins; that sample is not stored.
- Trigger inputs are ignored outside PRE.
- `reset`, including mid-capture: state IDLE, count 0, trig_pos 0, rd_data 0, rd_valid 0, rd_err 0. Buffer contents are don't-care.

## Timing
- Capture: the sample is written on the rising edge where `cap_valid`=1; count updates on the same edge.
- State transitions are registered and visible the cycle after the deciding sample.
- Read latency is 1 cycle: `rd_en` at edge N gives rd_data, rd_valid and rd_err after edge N+1. rd_valid is a 1-cycle pulse per request.
- Back-to-back reads sustain 1 per cycle.
- No combinational path from inputs to outputs.

## Structure
- A shared header/package `hack_trace_defs` holds:
  - state encodings;
  - trig_mode constants;
  - record field offsets/widths derived from DATA_W and ADDR_W.
- Sub-module `trace_ram`: DEPTH×REC_W, one write port and one synchronous read port, no reset on the array.
- The FSM, pointers, trigger compare and read-address arithmetic live in `hack_trace_buffer`.

## Test plan
Settings are DEPTH=8, POST_TRIG=2, driven from the running `Computer` with sum.hack unless noted.

1. **Immediate trigger**: mode 0; arm, then 5 samples → DONE after the 3rd sample; count=3, trig_pos=0, readout index 0..2 = first three pc values (0,1,2).
2. **PC match with wrap**: mode 1, trig_value=10; run → ≥10 samples before pc=10, so count=8 and trig_pos=5. Entry 5 has pc=10, entries 6–7 are the next two cycles, and entry 0 is the sample 5 cycles before the trigger.
3. **Write trigger**: mode 2, trig_value=17 → triggers on the first cycle with writeM=1 and addressM=17. That record has writeM=1 and outM equal to the stored value.
4. **Invalid read**: read in PRE → rd_err=1, rd_data=0. In DONE with count=3, rd_index=5 → rd_err=1; rd_index=2 → rd_err=0, with data after one cycle.
5. **Re-arm and simultaneity**: arm in POST together with cap_valid=1 → state PRE, count=0 next cycle, that sample absent from the buffer.
6. **Reset mid-capture**: assert reset asynchronously between edges while in POST → state=0, count=0 and rd_valid=0 immediately. After release, reads return rd_err=0 only after a fresh arm and capture.
